// File: rtl/ureg_ctrl_pkg.sv
// Shared types for the universal-register sequencer: FSM states, register modes, grant ids.
// The SCRUB state only exists when HAMMING_SCRUB_EN is defined.
package ureg_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
`ifdef HAMMING_SCRUB_EN
    ST_SCRUB = 3'd4,
`endif
    ST_FATAL = 3'd3
  } state_t;

  typedef enum logic {
    GNT_LD = 1'b0,
    GNT_TX = 1'b1
  } grant_t;

  localparam logic [1:0] MODE_SISO = 2'b00;
  localparam logic [1:0] MODE_SIPO = 2'b01;
  localparam logic [1:0] MODE_PISO = 2'b10;
  localparam logic [1:0] MODE_PIPO = 2'b11;

  function automatic logic [7:0] satInc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ureg_rr_arb.sv
// Two-requester round-robin arbiter; a lone requester always wins, a tie goes
// to whoever was not granted last. Last-grant resets to tx so load wins the first tie.
module ureg_rr_arb
  import ureg_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_req_ld,
  input  logic i_req_tx,
  input  logic i_acc_ld,
  input  logic i_acc_tx,
  output logic o_gnt_ld,
  output logic o_gnt_tx
);

  grant_t r_lastGrant;

  // History only moves on a completed transfer, never on a mere grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lastGrant <= GNT_TX;
    end else if (i_acc_ld) begin
      r_lastGrant <= GNT_LD;
    end else if (i_acc_tx) begin
      r_lastGrant <= GNT_TX;
    end
  end

  always_comb begin
    o_gnt_ld = i_req_ld && (!i_req_tx || (r_lastGrant == GNT_TX));
    o_gnt_tx = i_req_tx && (!i_req_ld || (r_lastGrant == GNT_LD));
  end

endmodule

// File: rtl/ureg_seq_ctrl.sv
// Sequencer driving a Hamming-protected universal shift register: parallel load,
// serial transmit, fatal lockout on double errors; HAMMING_SCRUB_EN adds single-error scrub.
module ureg_seq_ctrl
  import ureg_ctrl_pkg::*;
#(
  parameter int SHIFT_LEN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld_valid,
  output logic       ld_ready,
  input  logic [7:0] ld_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  input  logic       err_single,
  input  logic       err_double,
  input  logic [7:0] corr_data,
  output logic       reg_enable,
  output logic [1:0] reg_mode,
  output logic       reg_load,
  output logic [7:0] reg_parallel_in,
  output logic       busy,
  output logic       fatal,
  output logic [7:0] scrub_count
);

  localparam logic [3:0] CNT_LAST = 4'(SHIFT_LEN - 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_ldReady;
  logic       r_txReady;
  logic       r_txDone;
  logic       r_regEnable;
  logic       r_regLoad;
  logic [1:0] r_regMode;
  logic [7:0] r_regPin;
  logic       r_busy;
  logic       r_fatal;
  logic       w_gntLd;
  logic       w_gntTx;
  logic       w_errScrub;
  logic       w_accLd;
  logic       w_accTx;

`ifdef HAMMING_SCRUB_EN
  logic [7:0] r_scrubCount;
  assign w_errScrub  = err_single & ~err_double;
  assign scrub_count = r_scrubCount;
`else
  logic w_unused;
  assign w_errScrub  = 1'b0;
  assign w_unused    = ^{err_single, corr_data};
  assign scrub_count = 8'd0;
`endif

  // A pending error in IDLE outranks a handshake that lands on the same edge.
  assign w_accLd = (r_state == ST_IDLE) && !err_double && !w_errScrub && ld_valid && r_ldReady;
  assign w_accTx = (r_state == ST_IDLE) && !err_double && !w_errScrub && tx_valid && r_txReady;

  ureg_rr_arb u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_req_ld (ld_valid),
    .i_req_tx (tx_valid),
    .i_acc_ld (w_accLd),
    .i_acc_tx (w_accTx),
    .o_gnt_ld (w_gntLd),
    .o_gnt_tx (w_gntTx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_ldReady   <= 1'b0;
      r_txReady   <= 1'b0;
      r_txDone    <= 1'b0;
      r_regEnable <= 1'b0;
      r_regLoad   <= 1'b0;
      r_regMode   <= MODE_SISO;
      r_regPin    <= '0;
      r_busy      <= 1'b0;
      r_fatal     <= 1'b0;
`ifdef HAMMING_SCRUB_EN
      r_scrubCount <= '0;
`endif
    end else begin
      r_ldReady   <= 1'b0;
      r_txReady   <= 1'b0;
      r_txDone    <= 1'b0;
      r_regEnable <= 1'b0;
      r_regLoad   <= 1'b0;
      r_regMode   <= MODE_SISO;
      case (r_state)
        ST_IDLE: begin
          if (err_double) begin
            r_state <= ST_FATAL;
            r_fatal <= 1'b1;
            r_busy  <= 1'b1;
          end
`ifdef HAMMING_SCRUB_EN
          else if (w_errScrub) begin
            r_state      <= ST_SCRUB;
            r_busy       <= 1'b1;
            r_regEnable  <= 1'b1;
            r_regLoad    <= 1'b1;
            r_regMode    <= MODE_PIPO;
            r_regPin     <= corr_data;
            r_scrubCount <= satInc8(r_scrubCount);
          end
`endif
          else if (w_accLd) begin
            r_state     <= ST_LOAD;
            r_busy      <= 1'b1;
            r_regEnable <= 1'b1;
            r_regLoad   <= 1'b1;
            r_regMode   <= MODE_PIPO;
            r_regPin    <= ld_data;
          end else if (w_accTx) begin
            r_state     <= ST_SHIFT;
            r_cnt       <= '0;
            r_busy      <= 1'b1;
            r_regEnable <= 1'b1;
            r_regMode   <= MODE_PISO;
            r_txDone    <= (CNT_LAST == 4'd0);
          end else begin
            r_busy    <= 1'b0;
            r_ldReady <= w_gntLd;
            r_txReady <= w_gntTx;
          end
        end
        ST_LOAD: begin
          r_state   <= ST_IDLE;
          r_busy    <= 1'b0;
          r_ldReady <= w_gntLd;
          r_txReady <= w_gntTx;
        end
`ifdef HAMMING_SCRUB_EN
        ST_SCRUB: begin
          r_state   <= ST_IDLE;
          r_busy    <= 1'b0;
          r_ldReady <= w_gntLd;
          r_txReady <= w_gntTx;
        end
`endif
        ST_SHIFT: begin
          if (r_cnt == CNT_LAST) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_ldReady <= w_gntLd;
            r_txReady <= w_gntTx;
          end else begin
            r_cnt       <= r_cnt + 4'd1;
            r_busy      <= 1'b1;
            r_regEnable <= 1'b1;
            r_regMode   <= MODE_PISO;
            r_txDone    <= ((r_cnt + 4'd1) == CNT_LAST);
          end
        end
        ST_FATAL: begin
          r_fatal <= 1'b1;
          r_busy  <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ld_ready        = r_ldReady;
  assign tx_ready        = r_txReady;
  assign tx_done         = r_txDone;
  assign reg_enable      = r_regEnable;
  assign reg_mode        = r_regMode;
  assign reg_load        = r_regLoad;
  assign reg_parallel_in = r_regPin;
  assign busy            = r_busy;
  assign fatal           = r_fatal;

endmodule

// File: tb/tb_ureg_seq_ctrl.sv
// Self-checking bench for ureg_seq_ctrl: transaction-level model compared every cycle,
// plus directed literal checks. Honours HAMMING_SCRUB_EN like the design.
module tb_ureg_seq_ctrl;

  localparam int SL = 8;
`ifdef HAMMING_SCRUB_EN
  localparam bit SCRUB_EN = 1'b1;
`else
  localparam bit SCRUB_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       ld_valid, tx_valid, err_single, err_double;
  logic [7:0] ld_data, corr_data;
  logic       ld_ready, tx_ready, tx_done, reg_enable, reg_load, busy, fatal;
  logic [1:0] reg_mode;
  logic [7:0] reg_parallel_in, scrub_count;

  int nChecks = 0;
  int nPass   = 0;
  bit checkEn = 1'b0;
  bit logEn   = 1'b0;
  int grantLog[$];

  ureg_seq_ctrl #(.SHIFT_LEN(SL)) dut (
    .clk             (clk),
    .rst             (rst),
    .ld_valid        (ld_valid),
    .ld_ready        (ld_ready),
    .ld_data         (ld_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .tx_done         (tx_done),
    .err_single      (err_single),
    .err_double      (err_double),
    .corr_data       (corr_data),
    .reg_enable      (reg_enable),
    .reg_mode        (reg_mode),
    .reg_load        (reg_load),
    .reg_parallel_in (reg_parallel_in),
    .busy            (busy),
    .fatal           (fatal),
    .scrub_count     (scrub_count)
  );

  always #5 clk = ~clk;

  // Model: the block is either idle, locked in fatal, or running one operation
  // (load 1 cycle, scrub 1 cycle, transmit SL cycles) counted down per clock.
  int         mKind     = 0;   // 0 none, 1 load, 2 transmit, 3 scrub
  int         mLeft     = 0;
  int         mShiftIdx = 0;
  bit         mFatal    = 1'b0;
  bit         mLastTx   = 1'b1;
  bit         mLdRdy    = 1'b0;
  bit         mTxRdy    = 1'b0;
  logic [7:0] mPin      = 8'h00;
  logic [7:0] mScrub    = 8'h00;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mKind = 0; mLeft = 0; mShiftIdx = 0; mFatal = 1'b0; mLastTx = 1'b1;
      mLdRdy = 1'b0; mTxRdy = 1'b0; mPin = 8'h00; mScrub = 8'h00;
    end else begin
      if (mFatal) begin
      end else if (mKind != 0) begin
        mLeft = mLeft - 1;
        if (mKind == 2) mShiftIdx = mShiftIdx + 1;
        if (mLeft == 0) mKind = 0;
      end else if (err_double) begin
        mFatal = 1'b1;
      end else if (SCRUB_EN && err_single) begin
        mKind = 3; mLeft = 1; mPin = corr_data;
        if (mScrub != 8'd255) mScrub = mScrub + 8'd1;
      end else if (ld_valid && mLdRdy) begin
        mKind = 1; mLeft = 1; mPin = ld_data; mLastTx = 1'b0;
      end else if (tx_valid && mTxRdy) begin
        mKind = 2; mLeft = SL; mShiftIdx = 0; mLastTx = 1'b1;
      end
      if (!mFatal && mKind == 0) begin
        mLdRdy = ld_valid && (!tx_valid || mLastTx);
        mTxRdy = tx_valid && (!ld_valid || !mLastTx);
      end else begin
        mLdRdy = 1'b0;
        mTxRdy = 1'b0;
      end
    end
  end

  // Per-cycle comparison of every output against the model, away from the active edge.
  always @(negedge clk) begin
    logic [24:0] actVec, expVec;
    logic        eLoad;
    logic [1:0]  eMode;
    if (checkEn) begin
      eLoad  = (mKind == 1) || (mKind == 3);
      eMode  = (mKind == 2) ? 2'b10 : (eLoad ? 2'b11 : 2'b00);
      expVec = {mLdRdy, mTxRdy, (mKind == 2) && (mShiftIdx == SL - 1), mKind != 0,
                eMode, eLoad, mPin, mFatal || (mKind != 0), mFatal, mScrub};
      actVec = {ld_ready, tx_ready, tx_done, reg_enable, reg_mode, reg_load,
                reg_parallel_in, busy, fatal, scrub_count};
      nChecks++;
      if (actVec === expVec) nPass++;
      else $display("[TB] FAIL cycleModel t=%0t actual=%h required=%h", $time, actVec, expVec);
    end
  end

  // A handshake is visible as valid&&ready in the cycle before the edge that takes it.
  always @(negedge clk) begin
    if (logEn && !rst) begin
      if (ld_valid && ld_ready) grantLog.push_back(1);
      if (tx_valid && tx_ready) grantLog.push_back(2);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic ldV, input logic [7:0] ldD, input logic txV,
                               input logic errS, input logic errD, input logic [7:0] corr);
    ld_valid = ldV; ld_data = ldD; tx_valid = txV;
    err_single = errS; err_double = errD; corr_data = corr;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual === expected) nPass++;
    else $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int shiftCycles, doneAt, doneCount, g;
    rst = 1'b1;
    applyStimulus(0, 8'h00, 0, 0, 0, 8'h00);
    #1 checkEn = 1'b1;
    tick(); tick();
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetMode", reg_mode, 0);
    checkOutput("resetPin", reg_parallel_in, 0);
    rst = 1'b0;
    tick();

    // Single parallel load of A5.
    applyStimulus(1, 8'hA5, 0, 0, 0, 8'h00);
    tick();
    checkOutput("ldReadyRaised", ld_ready, 1);
    tick();
    applyStimulus(0, 8'h00, 0, 0, 0, 8'h00);
    checkOutput("loadMode", reg_mode, 2'b11);
    checkOutput("loadStrobe", reg_load, 1);
    checkOutput("loadData", reg_parallel_in, 8'hA5);
    tick();
    checkOutput("loadReturnIdle", busy, 0);
    checkOutput("loadStrobeEnd", reg_load, 0);
    tick();

    // Transmit: 8 shift cycles, tx_done only on the last one.
    applyStimulus(0, 8'h00, 1, 0, 0, 8'h00);
    tick(); tick();
    applyStimulus(0, 8'h00, 0, 0, 0, 8'h00);
    shiftCycles = 0; doneAt = -1; doneCount = 0;
    for (int i = 0; i < 12; i++) begin
      if (reg_enable && reg_mode == 2'b10) shiftCycles++;
      if (tx_done) begin doneAt = shiftCycles; doneCount++; end
      tick();
    end
    checkOutput("shiftCycles", shiftCycles, 8);
    checkOutput("txDonePosition", doneAt, 8);
    checkOutput("txDoneCount", doneCount, 1);

    // err_double while shifting is ignored.
    applyStimulus(0, 8'h00, 1, 0, 0, 8'h00);
    tick(); tick();
    applyStimulus(0, 8'h00, 0, 1, 1, 8'h00);
    tick(); tick();
    applyStimulus(0, 8'h00, 0, 0, 0, 8'h00);
    repeat (10) tick();
    checkOutput("shiftErrIgnored", fatal, 0);

    // Single error in idle: scrub when enabled, ignored otherwise.
    applyStimulus(0, 8'h00, 0, 1, 0, 8'h26);
    tick();
    applyStimulus(0, 8'h00, 0, 0, 0, 8'h00);
    checkOutput("scrubCountOne", scrub_count, SCRUB_EN ? 1 : 0);
    checkOutput("scrubData", reg_parallel_in, SCRUB_EN ? 8'h26 : 8'hA5);
    tick(); tick();

    // Continuous single errors: one scrub every two cycles, well past 255.
    applyStimulus(0, 8'h00, 0, 1, 0, 8'h11);
    repeat (600) tick();
    applyStimulus(0, 8'h00, 0, 0, 0, 8'h00);
    tick(); tick();
    checkOutput("scrubSaturate", scrub_count, SCRUB_EN ? 255 : 0);

    // Both requesters held after reset: load, tx, load, tx.
    pulseReset();
    logEn = 1'b1;
    applyStimulus(1, 8'h5C, 1, 0, 0, 8'h00);
    repeat (20) tick();
    applyStimulus(0, 8'h00, 0, 0, 0, 8'h00);
    logEn = 1'b0;
    repeat (12) tick();
    checkOutput("grantLogLen", grantLog.size() >= 4, 1);
    for (int i = 0; i < 4; i++) begin
      g = (i < grantLog.size()) ? grantLog[i] : 0;
      checkOutput($sformatf("grant%0d", i), g, (i % 2 == 0) ? 1 : 2);
    end

    // Reset at shift cycle 3 aborts without tx_done; next request is served.
    applyStimulus(0, 8'h00, 1, 0, 0, 8'h00);
    tick(); tick();
    applyStimulus(0, 8'h00, 0, 0, 0, 8'h00);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    checkOutput("abortEnable", reg_enable, 0);
    checkOutput("abortMode", reg_mode, 0);
    checkOutput("abortBusy", busy, 0);
    tick();
    rst = 1'b0;
    doneCount = 0;
    for (int i = 0; i < 10; i++) begin
      if (tx_done) doneCount++;
      tick();
    end
    checkOutput("abortNoDone", doneCount, 0);
    applyStimulus(1, 8'h3C, 0, 0, 0, 8'h00);
    tick(); tick();
    applyStimulus(0, 8'h00, 0, 0, 0, 8'h00);
    checkOutput("postAbortLoad", reg_parallel_in, 8'h3C);
    tick(); tick();

    // Double error (with single also high) in idle: fatal lockout despite requests.
    applyStimulus(1, 8'h77, 1, 1, 1, 8'h00);
    tick();
    applyStimulus(1, 8'h77, 1, 0, 0, 8'h00);
    repeat (5) tick();
    checkOutput("fatalFlag", fatal, 1);
    checkOutput("fatalLdReady", ld_ready, 0);
    checkOutput("fatalTxReady", tx_ready, 0);
    checkOutput("fatalEnable", reg_enable, 0);
    checkOutput("fatalScrubNone", scrub_count, 0);
    applyStimulus(0, 8'h00, 0, 0, 0, 8'h00);
    pulseReset();
    checkOutput("fatalCleared", fatal, 0);
    applyStimulus(1, 8'h5A, 0, 0, 0, 8'h00);
    tick(); tick();
    applyStimulus(0, 8'h00, 0, 0, 0, 8'h00);
    checkOutput("postFatalLoad", reg_parallel_in, 8'h5A);
    repeat (3) tick();

    checkEn = 1'b0;
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
